reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning register and data bus width in bits.
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 4, meaning register index width; the bank holds 2**REG_ADDR_WIDTH registers.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 en_in  input  1  writeback write enable from pipeline stage 5.
REQ-006 addr_in  input  REG_ADDR_WIDTH  writeback destination register.
REQ-007 data_in  input  DATA_WIDTH signed  writeback data.
REQ-008 rd_addr_a  input  REG_ADDR_WIDTH  read port A index.
REQ-009 rd_addr_b  input  REG_ADDR_WIDTH  read port B index.
REQ-010 issue_en  input  1  an instruction with a register destination is issued this cycle.
REQ-011 issue_addr  input  REG_ADDR_WIDTH  destination of the issued instruction.
REQ-012 data_a  output  DATA_WIDTH signed  registered read data, port A.
REQ-013 data_b  output  DATA_WIDTH signed  registered read data, port B.
REQ-014 hazard  output  1  combinational; a read port addresses a register with an outstanding write.
REQ-015 pending  output  2**REG_ADDR_WIDTH  scoreboard vector, bit i = write to register i outstanding.

Function
REQ-016 On a rising edge with en_in=1, register addr_in SHALL take data_in; en_in=0 SHALL leave all registers unchanged.
REQ-017 data_a/data_b SHALL present the register addressed by rd_addr_a/rd_addr_b, registered: one-cycle latency.
REQ-018 Both read ports SHALL be independent; equal rd_addr_a and rd_addr_b SHALL return identical data.
REQ-019 issue_en=1 SHALL set pending[issue_addr] at the rising edge.
REQ-020 en_in=1 SHALL clear pending[addr_in] at the rising edge.
REQ-021 Simultaneous issue_en and en_in to the same address SHALL leave the pending bit set (new writer in flight); to different addresses, both updates SHALL apply.
REQ-022 Clearing an already-clear pending bit or setting an already-set bit SHALL be harmless and change nothing else.
REQ-023 hazard SHALL equal (pending[rd_addr_a] and not cleared-this-cycle-A) or (pending[rd_addr_b] and not cleared-this-cycle-B), where cleared-this-cycle-X is en_in=1 with addr_in=rd_addr_X, only when REG_BYPASS_EN is defined; otherwise the clear term is absent.
REQ-024 Register index 0 SHALL be an ordinary writable register.
REQ-025 Data arithmetic: none; values SHALL be stored and returned bit-exact, no sign or width conversion.

Reset
REQ-026 RST=0 SHALL immediately, without waiting for clk_in, force all registers, data_a, data_b and pending to zero; hazard therefore reads 0.
REQ-027 Reset asserted mid-operation SHALL discard any write or issue in that cycle; the first update SHALL occur at the first rising edge with RST=1.

Configuration
REQ-028 Macro REG_BYPASS_EN defined: when en_in=1 and addr_in equals a read address, that port SHALL capture data_in (write-to-read forwarding) and hazard SHALL omit that port per REQ-023.
REQ-029 Macro REG_BYPASS_EN undefined: the read port SHALL capture the pre-write register value, and hazard SHALL stay asserted for that port in that cycle.

Verification
REQ-030 Reset then write 0x1234 to r3, next cycle read rd_addr_a=3 -> data_a=0x1234 one edge later; all other reads 0.
REQ-031 Same-cycle write 0x00AA to r5 with rd_addr_a=5, r5 previously 0x0011 -> data_a=0x00AA with REG_BYPASS_EN, 0x0011 without.
REQ-032 issue_en to r7, then rd_addr_b=7 -> hazard=1, pending[7]=1; en_in to r7 -> pending[7]=0 after edge, hazard=0.
REQ-033 issue_en and en_in both to r2 in one cycle, r2 pending -> pending[2] stays 1; issue r4 with writeback r2 -> pending[4]=1, pending[2]=0.
REQ-034 Write 0x7FFF to r1 and issue r6, assert RST=0 between edges -> all outputs 0 immediately; after release, read r1 -> 0x0000, pending=0.
REQ-035 Write -1 (0xFFFF) to r0 and r15, read both ports simultaneously -> data_a=data_b=0xFFFF signed -1.

Source files
------------

// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank -- register file with writeback port, two registered read ports
// and a pending-write scoreboard used for hazard detection.
//
// Optional feature macro: REG_BYPASS_EN
//   defined   : a same-cycle writeback is forwarded into a read port
//               addressing the same register, and that port's hazard term
//               is masked for the cycle.
//   undefined : read ports capture the pre-write register contents and the
//               hazard term stays asserted until the pending bit clears.
//
// Ports
//   clk_in      single clock, all state on rising edge
//   RST         asynchronous active-low reset
//   en_in       writeback enable
//   addr_in     writeback destination register
//   data_in     writeback data
//   rd_addr_a   read port A index
//   rd_addr_b   read port B index
//   issue_en    an instruction with a register destination issues this cycle
//   issue_addr  destination register of the issued instruction
//   data_a      registered read data, port A
//   data_b      registered read data, port B
//   hazard      combinational: a read port addresses an outstanding write
//   pending     scoreboard, bit i = write to register i outstanding
// ---------------------------------------------------------------------------
module reg_bank #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                              clk_in,
    input  logic                              RST,
    input  logic                              en_in,
    input  logic        [REG_ADDR_WIDTH-1:0]  addr_in,
    input  logic signed [DATA_WIDTH-1:0]      data_in,
    input  logic        [REG_ADDR_WIDTH-1:0]  rd_addr_a,
    input  logic        [REG_ADDR_WIDTH-1:0]  rd_addr_b,
    input  logic                              issue_en,
    input  logic        [REG_ADDR_WIDTH-1:0]  issue_addr,
    output logic signed [DATA_WIDTH-1:0]      data_a,
    output logic signed [DATA_WIDTH-1:0]      data_b,
    output logic                              hazard,
    output logic        [2**REG_ADDR_WIDTH-1:0] pending
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

    logic signed [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]          pending_next;
    logic                         fwd_a;
    logic                         fwd_b;

`ifdef REG_BYPASS_EN
    assign fwd_a = en_in && (addr_in == rd_addr_a);
    assign fwd_b = en_in && (addr_in == rd_addr_b);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (en_in) begin
            regs[addr_in] <= data_in;
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= fwd_a ? data_in : regs[rd_addr_a];
            data_b <= fwd_b ? data_in : regs[rd_addr_b];
        end
    end

    // Set is applied after clear so a new writer issued to the register
    // being written back keeps the bit set.
    always_comb begin
        pending_next = pending;
        if (en_in) begin
            pending_next[addr_in] = 1'b0;
        end
        if (issue_en) begin
            pending_next[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hazard = (pending[rd_addr_a] && !fwd_a) ||
                    (pending[rd_addr_b] && !fwd_b);

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 2**AW;

`ifdef REG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                  clk_in = 1'b0;
    logic                  RST;
    logic                  en_in;
    logic        [AW-1:0]  addr_in;
    logic signed [DW-1:0]  data_in;
    logic        [AW-1:0]  rd_addr_a;
    logic        [AW-1:0]  rd_addr_b;
    logic                  issue_en;
    logic        [AW-1:0]  issue_addr;
    logic signed [DW-1:0]  data_a;
    logic signed [DW-1:0]  data_b;
    logic                  hazard;
    logic        [NR-1:0]  pending;

    reg_bank #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk_in     (clk_in),
        .RST        (RST),
        .en_in      (en_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .data_a     (data_a),
        .data_b     (data_b),
        .hazard     (hazard),
        .pending    (pending)
    );

    always #5 clk_in = ~clk_in;

    // reference model state
    int unsigned m_mem [NR];
    int unsigned m_a;
    int unsigned m_b;
    bit          m_pend [NR];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [63:0] model_pend_vec();
        logic [63:0] v = '0;
        for (int i = 0; i < NR; i++) begin
            if (m_pend[i]) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic bit model_hazard(int ra, int rb, bit en, int wa);
        bit ha = m_pend[ra] && !(BYPASS && en && wa == ra);
        bit hb = m_pend[rb] && !(BYPASS && en && wa == rb);
        return ha || hb;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = 0;
            m_pend[i] = 1'b0;
        end
        m_a = 0;
        m_b = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_a"},  {48'b0, $unsigned(data_a)}, 64'(m_a));
        check({tag, ".data_b"},  {48'b0, $unsigned(data_b)}, 64'(m_b));
        check({tag, ".pending"}, 64'(pending), model_pend_vec());
    endtask

    // Called at a falling edge: drive, check hazard, clock, update model, check.
    task automatic cycle(input string tag, input bit en, input int wa, input int unsigned wd,
                         input int ra, input int rb, input bit iss, input int ia);
        en_in      = en;
        addr_in    = AW'(wa);
        data_in    = DW'(wd);
        rd_addr_a  = AW'(ra);
        rd_addr_b  = AW'(rb);
        issue_en   = iss;
        issue_addr = AW'(ia);
        #1;
        check({tag, ".hazard"}, 64'(hazard), 64'(model_hazard(ra, rb, en, wa)));
        @(posedge clk_in);
        m_a = (BYPASS && en && wa == ra) ? (wd & 32'hFFFF) : m_mem[ra];
        m_b = (BYPASS && en && wa == rb) ? (wd & 32'hFFFF) : m_mem[rb];
        if (en) begin
            m_mem[wa]  = wd & 32'hFFFF;
            m_pend[wa] = 1'b0;
        end
        if (iss) m_pend[ia] = 1'b1;
        @(negedge clk_in);
        check_outputs(tag);
    endtask

    task automatic idle();
        en_in = 1'b0; addr_in = '0; data_in = '0;
        rd_addr_a = '0; rd_addr_b = '0; issue_en = 1'b0; issue_addr = '0;
    endtask

    // Reset asserted between edges with a write and an issue in flight;
    // the edge seen during reset must not apply them.
    task automatic reset_mid(input string tag, input int wa, input int unsigned wd, input int ia);
        en_in = 1'b1; addr_in = AW'(wa); data_in = DW'(wd);
        issue_en = 1'b1; issue_addr = AW'(ia);
        #2;
        RST = 1'b0;
        #1;
        check({tag, ".rst_data_a"},  {48'b0, $unsigned(data_a)}, 64'd0);
        check({tag, ".rst_data_b"},  {48'b0, $unsigned(data_b)}, 64'd0);
        check({tag, ".rst_pending"}, 64'(pending), 64'd0);
        check({tag, ".rst_hazard"},  64'(hazard), 64'd0);
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        idle();
        RST = 1'b1;
    endtask

    initial begin
        idle();
        RST = 1'b0;
        model_reset();
        #1;
        check("reset.data_a",  {48'b0, $unsigned(data_a)}, 64'd0);
        check("reset.data_b",  {48'b0, $unsigned(data_b)}, 64'd0);
        check("reset.pending", 64'(pending), 64'd0);
        check("reset.hazard",  64'(hazard), 64'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        RST = 1'b1;

        // write r3, then read it back on A; B reads an untouched register
        cycle("wr_r3", 1, 3, 32'h1234, 0, 0, 0, 0);
        cycle("rd_r3", 0, 0, 0, 3, 4, 0, 0);
        check("rd_r3.value", {48'b0, $unsigned(data_a)}, 64'h1234);
        check("rd_r4.value", {48'b0, $unsigned(data_b)}, 64'h0);

        // same-cycle write and read of r5
        cycle("wr_r5", 1, 5, 32'h0011, 0, 0, 0, 0);
        cycle("wr_rd_r5", 1, 5, 32'h00AA, 5, 3, 0, 0);
        check("wr_rd_r5.value", {48'b0, $unsigned(data_a)}, BYPASS ? 64'h00AA : 64'h0011);

        // scoreboard set, hazard, clear via writeback
        cycle("iss_r7", 0, 0, 0, 0, 0, 1, 7);
        cycle("haz_r7", 0, 0, 0, 0, 7, 0, 0);
        check("haz_r7.pend7", 64'(pending[7]), 64'd1);
        cycle("wb_r7", 1, 7, 32'h0777, 0, 7, 0, 0);
        check("wb_r7.pend7", 64'(pending[7]), 64'd0);
        cycle("post_r7", 0, 0, 0, 0, 7, 0, 0);

        // simultaneous issue and writeback
        cycle("iss_r2", 0, 0, 0, 0, 0, 1, 2);
        cycle("iss_wb_r2", 1, 2, 32'h0222, 2, 0, 1, 2);
        check("iss_wb_r2.pend2", 64'(pending[2]), 64'd1);
        cycle("iss4_wb2", 1, 2, 32'h0223, 0, 0, 1, 4);
        check("iss4_wb2.pend4", 64'(pending[4]), 64'd1);
        check("iss4_wb2.pend2", 64'(pending[2]), 64'd0);

        // reset in the middle of a write to r1 and an issue of r6
        cycle("wr_r1_pre", 1, 1, 32'h0101, 1, 2, 0, 0);
        reset_mid("rst_mid", 1, 32'h7FFF, 6);
        cycle("rd_r1_post", 0, 0, 0, 1, 6, 0, 0);
        check("rd_r1_post.value", {48'b0, $unsigned(data_a)}, 64'h0);
        check("rd_r1_post.pend",  64'(pending), 64'h0);

        // -1 in the lowest and highest registers, read on both ports
        cycle("wr_r0_m1",  1, 0,  32'hFFFF, 0, 0, 0, 0);
        cycle("wr_r15_m1", 1, 15, 32'hFFFF, 0, 0, 0, 0);
        cycle("rd_r0_r15", 0, 0, 0, 0, 15, 0, 0);
        check("rd_r0.neg1",  64'(signed'(data_a) == -16'sd1), 64'd1);
        check("rd_r15.neg1", 64'(signed'(data_b) == -16'sd1), 64'd1);

        // randomized traffic; addresses sometimes narrowed to force collisions
        for (int n = 0; n < 400; n++) begin
            int unsigned lim;
            lim = ($urandom_range(0, 1) == 1) ? 3 : NR - 1;
            if ($urandom_range(0, 49) == 0) begin
                reset_mid("rnd_rst", int'($urandom_range(0, lim)), $urandom_range(0, 32'hFFFF),
                          int'($urandom_range(0, lim)));
            end else begin
                cycle("rnd",
                      bit'($urandom_range(0, 1)),
                      int'($urandom_range(0, lim)),
                      $urandom_range(0, 32'hFFFF),
                      int'($urandom_range(0, lim)),
                      int'($urandom_range(0, lim)),
                      bit'($urandom_range(0, 1)),
                      int'($urandom_range(0, lim)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
